// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the 32-bit machine word, branch-resolve FSM states and the sequential PC increment.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        UPD,
        FLUSH
    } brc_state_t;

    localparam word_t BR_PC_INC = 32'd4;

endpackage

// File: rtl/br_perf_cnt.sv
// Purpose: saturating pair of event counters (resolved branches, mispredicts).
// Latency: count visible the cycle after the increment strobe.
// Backpressure: none; strobes are single-cycle events, counters stick at all-ones.
module br_perf_cnt (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        inc_br,
    input  logic        inc_mis,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (inc_br && (br_count != 32'hFFFF_FFFF))
                br_count <= br_count + 32'd1;
            if (inc_mis && (mispred_count != 32'hFFFF_FFFF))
                mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Purpose: resolves EX branches into predictor updates, fetch redirects and IF/ID flushes (BR_CTRL_PERF_EN adds counters).
// Latency: all outputs registered, valid the cycle after a branch is accepted.
// Backpressure: pc_en low holds the pending update; flush runs its fixed length regardless.
module br_resolve_ctrl
    import cpu_types_pkg::*;
#(
    parameter int IDX_W        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred,
    input  logic [31:0]      ex_pred_target,
    input  logic             pc_en,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [IDX_W-1:0] upd_index,
    output logic [31:0]      upd_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush
`ifdef BR_CTRL_PERF_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      mispred_count
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    brc_state_t state;
    logic [2:0] cnt;
    logic       accept;
    logic       mispred;
    word_t      fix_pc;

    // Branches arriving while flushing are wrong-path and never accepted.
    assign accept  = ex_valid & ex_is_br & pc_en & (state != FLUSH);
    assign mispred = (ex_pred != ex_taken) |
                     (ex_pred & ex_taken & (ex_pred_target != ex_target));
    assign fix_pc  = ex_taken ? ex_target : ex_pc + BR_PC_INC;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            cnt            <= '0;
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            upd_index      <= '0;
            upd_target     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept) begin
                // Any older pending update is written this cycle (pc_en is high).
                upd_valid  <= 1'b1;
                upd_taken  <= ex_taken;
                upd_index  <= ex_pc[IDX_W+1:2];
                upd_target <= ex_target;
                if (mispred) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= fix_pc;
                    flush          <= 1'b1;
                    cnt            <= FLUSH_INIT;
                    state          <= FLUSH;
                end else begin
                    state <= UPD;
                end
            end else begin
                if (upd_valid && pc_en)
                    upd_valid <= 1'b0;
                case (state)
                    UPD: begin
                        if (pc_en)
                            state <= IDLE;
                    end
                    FLUSH: begin
                        if (cnt == '0) begin
                            flush <= 1'b0;
                            state <= (pc_en || !upd_valid) ? IDLE : UPD;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BR_CTRL_PERF_EN
    br_perf_cnt u_perf (
        .CLK           (CLK),
        .nRST          (nRST),
        .inc_br        (accept),
        .inc_mis       (accept & mispred),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Scoreboard bench for br_resolve_ctrl: directed branches push expected updates, redirects and flush lengths.
module tb_br_resolve_ctrl;
    import cpu_types_pkg::*;

    localparam int IDX_W        = 3;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        logic       taken;
        logic [2:0] idx;
        word_t      tgt;
    } exp_upd_t;

    logic             CLK;
    logic             nRST;
    logic             ex_valid;
    logic             ex_is_br;
    logic             ex_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             ex_pred;
    logic [31:0]      ex_pred_target;
    logic             pc_en;
    logic             upd_valid;
    logic             upd_taken;
    logic [IDX_W-1:0] upd_index;
    logic [31:0]      upd_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
`ifdef BR_CTRL_PERF_EN
    logic [31:0]      br_count;
    logic [31:0]      mispred_count;
`endif

    br_resolve_ctrl #(.IDX_W(IDX_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred        (ex_pred),
        .ex_pred_target (ex_pred_target),
        .pc_en          (pc_en),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .upd_index      (upd_index),
        .upd_target     (upd_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef BR_CTRL_PERF_EN
        ,
        .br_count       (br_count),
        .mispred_count  (mispred_count)
`endif
    );

    int       total = 0;
    int       bad   = 0;
    logic     mon_en = 1'b0;
    int       fl_run = 0;
    exp_upd_t upd_q[$];
    word_t    rd_q[$];
    int       fl_q[$];
    exp_upd_t mon_u;
    word_t    mon_rpc;
    int       mon_fl;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
    endtask

    // Monitor: compare each predictor write, each redirect and each flush burst.
    always @(negedge CLK) begin
        if (!mon_en) begin
            fl_run = 0;
        end else begin
            if (upd_valid && pc_en) begin
                if (upd_q.size() == 0) unexpected("upd_write");
                else begin
                    mon_u = upd_q.pop_front();
                    chk("upd_taken", 32'(upd_taken), 32'(mon_u.taken));
                    chk("upd_index", 32'(upd_index), 32'(mon_u.idx));
                    chk("upd_target", upd_target, mon_u.tgt);
                end
            end
            if (redirect_valid) begin
                if (rd_q.size() == 0) unexpected("redirect");
                else begin
                    mon_rpc = rd_q.pop_front();
                    chk("redirect_pc", redirect_pc, mon_rpc);
                end
            end
            if (flush) fl_run++;
            else if (fl_run > 0) begin
                if (fl_q.size() == 0) unexpected("flush");
                else begin
                    mon_fl = fl_q.pop_front();
                    chk("flush_len", 32'(fl_run), 32'(mon_fl));
                end
                fl_run = 0;
            end
        end
    end

    task automatic br(input word_t pc, input word_t tgt, input logic pred, input word_t ptgt,
                      input logic taken, input logic acc, input logic [2:0] e_idx,
                      input logic e_mis, input word_t e_rpc);
        exp_upd_t u;
        ex_valid = 1'b1; ex_is_br = 1'b1; pc_en = 1'b1;
        ex_pc = pc; ex_target = tgt; ex_pred = pred; ex_pred_target = ptgt; ex_taken = taken;
        if (acc) begin
            u.taken = taken; u.idx = e_idx; u.tgt = tgt;
            upd_q.push_back(u);
            if (e_mis) begin
                rd_q.push_back(e_rpc);
                fl_q.push_back(FLUSH_CYCLES);
            end
        end
        @(posedge CLK); #1;
        ex_valid = 1'b0; ex_is_br = 1'b0;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0; ex_is_br = 1'b0; pc_en = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; ex_valid = 1'b0; ex_is_br = 1'b0; ex_taken = 1'b0; ex_pc = '0;
        ex_target = '0; ex_pred = 1'b0; ex_pred_target = '0; pc_en = 1'b0;
        #3;
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_upd_index", 32'(upd_index), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1; mon_en = 1'b1;
        idle(2);

        // Correct not-taken at 0x40.
        br(32'h40, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0);
        @(negedge CLK);
        chk("nt_upd_valid", 32'(upd_valid), 32'd1);
        chk("nt_flush", 32'(flush), 32'd0);
        chk("nt_redirect", 32'(redirect_valid), 32'd0);
        @(posedge CLK); #1;
        idle(1);
        // Direction mispredict, taken to 0x100.
        br(32'h44, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h100);
        idle(3);
        // Target mispredict.
        br(32'h48, 32'h300, 1'b1, 32'h200, 1'b1, 1'b1, 3'd2, 1'b1, 32'h300);
        idle(3);
        // Correct not-taken at top of address space.
        br(32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 3'd7, 1'b0, 32'h0);
        idle(2);
        // Predicted taken, actually not-taken at top: redirect wraps to 0.
        br(32'hFFFF_FFFC, 32'h10, 1'b1, 32'h10, 1'b0, 1'b1, 3'd7, 1'b1, 32'h0);
        idle(3);

        // Stall: update held while pc_en is low.
        br(32'h50, 32'h60, 1'b1, 32'h60, 1'b1, 1'b1, 3'd4, 1'b0, 32'h0);
        pc_en = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("stall_upd_valid", 32'(upd_valid), 32'd1);
            chk("stall_upd_index", 32'(upd_index), 32'd4);
            chk("stall_upd_target", upd_target, 32'h60);
            @(posedge CLK); #1;
        end
        pc_en = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("stall_release", 32'(upd_valid), 32'd0);
        @(posedge CLK); #1;

        // Mispredict, then a wrong-path branch during FLUSH.
        br(32'h60, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 3'd0, 1'b1, 32'h64);
        br(32'h64, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0);
        idle(3);

        // Back-to-back correct predictions.
        br(32'h70, 32'h90, 1'b0, 32'h0, 1'b0, 1'b1, 3'd4, 1'b0, 32'h0);
        br(32'h74, 32'hA0, 1'b1, 32'hA0, 1'b1, 1'b1, 3'd5, 1'b0, 32'h0);
        @(negedge CLK);
        chk("b2b_upd_valid", 32'(upd_valid), 32'd1);
        chk("b2b_upd_index", 32'(upd_index), 32'd5);
        @(posedge CLK); #1;
        idle(2);

        // Reset in the middle of a flush.
        br(32'h80, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, 32'h40);
        mon_en = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rstmid_flush", 32'(flush), 32'd0);
        chk("rstmid_upd_valid", 32'(upd_valid), 32'd0);
        chk("rstmid_redirect", 32'(redirect_valid), 32'd0);
        upd_q.delete(); rd_q.delete(); fl_q.delete();
        @(posedge CLK); #1;
        nRST = 1'b1; mon_en = 1'b1;
        idle(2);

        // Five branches, two mispredicts.
        br(32'h100, 32'h120, 1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0);
        br(32'h104, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h300);
        idle(3);
        br(32'h108, 32'h400, 1'b1, 32'h400, 1'b1, 1'b1, 3'd2, 1'b0, 32'h0);
        br(32'h10C, 32'h410, 1'b0, 32'h0, 1'b0, 1'b1, 3'd3, 1'b0, 32'h0);
        br(32'h110, 32'h500, 1'b1, 32'h500, 1'b0, 1'b1, 3'd4, 1'b1, 32'h114);
        idle(4);
`ifdef BR_CTRL_PERF_EN
        chk("br_count", br_count, 32'd5);
        chk("mispred_count", mispred_count, 32'd2);
`endif

        chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("fl_q_drained", 32'(fl_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
